// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between two masters.
// Requests issue combinationally onto the memory bus; responses return one cycle later.
module dmem_arbiter #(
    parameter int SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [31:0] p0_addr,
    input  logic        p0_write,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wmask,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_addr,
    input  logic        p1_write,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wmask,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_sdata,
    output logic        mem_lenable,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_ldata
);

    localparam logic [29:0] SIZE_W = 30'(SIZE);

    logic        rr_last;
    logic        rsp_pend;
    logic        rsp_port;
    logic        rsp_rd;
    logic        rsp_err;

    logic        grant0;
    logic        grant1;
    logic        issue;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        g_write;
    logic [3:0]  g_wmask;
    logic        g_oor;
    logic [31:0] rsp_data;

    function automatic logic out_of_range(input logic [31:0] addr);
        return addr[31:2] >= SIZE_W;
    endfunction

    // Issue stage: grant selection and memory drive
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (p0_valid && p1_valid) begin
                grant0 = rr_last;
                grant1 = !rr_last;
            end else begin
                grant0 = p0_valid;
                grant1 = p1_valid;
            end
        end
    end

    assign issue    = grant0 | grant1;
    assign p0_ready = grant0;
    assign p1_ready = grant1;

    assign g_addr  = grant1 ? p1_addr  : p0_addr;
    assign g_wdata = grant1 ? p1_wdata : p0_wdata;
    assign g_write = grant1 ? p1_write : p0_write;
    assign g_wmask = grant1 ? p1_wmask : p0_wmask;
    assign g_oor   = out_of_range(g_addr);

    assign mem_addr    = issue ? g_addr  : 32'h0;
    assign mem_sdata   = issue ? g_wdata : 32'h0;
    assign mem_lenable = issue && !g_write && !g_oor;
    assign mem_mask    = (issue && g_write && !g_oor) ? g_wmask : 4'h0;

    // Response stage: remember who issued what, for the cycle the memory answers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last  <= 1'b1;
            rsp_pend <= 1'b0;
            rsp_port <= 1'b0;
            rsp_rd   <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_pend <= issue;
            if (issue) begin
                rr_last  <= grant1;
                rsp_port <= grant1;
                rsp_rd   <= !g_write;
                rsp_err  <= g_oor;
            end
        end
    end

    assign rsp_data = (rsp_pend && rsp_rd && !rsp_err) ? mem_ldata : 32'h0;

    assign p0_resp_valid = rsp_pend && !rsp_port;
    assign p0_resp_err   = rsp_pend && !rsp_port && rsp_err;
    assign p0_resp_rdata = !rsp_port ? rsp_data : 32'h0;

    assign p1_resp_valid = rsp_pend && rsp_port;
    assign p1_resp_err   = rsp_pend && rsp_port && rsp_err;
    assign p1_resp_rdata = rsp_port ? rsp_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of arbitration and memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_valid, p0_ready, p0_write, p0_resp_valid, p0_resp_err;
    logic [31:0] p0_addr, p0_wdata, p0_resp_rdata;
    logic [3:0]  p0_wmask;
    logic        p1_valid, p1_ready, p1_write, p1_resp_valid, p1_resp_err;
    logic [31:0] p1_addr, p1_wdata, p1_resp_rdata;
    logic [3:0]  p1_wmask;
    logic [31:0] mem_addr, mem_sdata, mem_ldata;
    logic        mem_lenable;
    logic [3:0]  mem_mask;

    always #5 clk = ~clk;

    dmem_arbiter #(.SIZE(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_write(p0_write),
        .p0_wdata(p0_wdata), .p0_wmask(p0_wmask), .p0_resp_valid(p0_resp_valid),
        .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_write(p1_write),
        .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_resp_valid(p1_resp_valid),
        .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata), .mem_lenable(mem_lenable),
        .mem_mask(mem_mask), .mem_ldata(mem_ldata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 8) return 32'h11223344;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Synchronous-read memory the arbiter drives
    logic        dev_init = 1'b0;
    logic [31:0] dmem [0:4095];
    always @(posedge clk) begin
        if (!dev_init) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= init_word(i);
            dev_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) dmem[mem_addr[13:2]][8*b +: 8] <= mem_sdata[8*b +: 8];
            if (mem_lenable) mem_ldata <= dmem[mem_addr[13:2]];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:4095];
    int          rr_model;
    int          last_g;
    logic        pend;
    int          pport;
    logic        perr;
    logic [31:0] prdata;
    logic [1:0]  obs_rdy;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr_model = 1;
        pend     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({p0_ready, p1_ready, p0_resp_valid, p1_resp_valid,
                                p0_resp_err, p1_resp_err, mem_lenable, mem_mask}), 64'h0);
        chk({tag, "_rdata"}, {p0_resp_rdata, p1_resp_rdata}, 64'h0);
        chk({tag, "_bus"}, {mem_addr, mem_sdata}, 64'h0);
    endtask

    // One clock cycle: drive, check against the model, then advance the model
    task automatic cyc(input logic v0, input logic [31:0] a0, input logic w0,
                       input logic [31:0] d0, input logic [3:0] m0,
                       input logic v1, input logic [31:0] a1, input logic w1,
                       input logic [31:0] d1, input logic [3:0] m1);
        int          g;
        logic [31:0] ga, gd;
        logic        gw, oor;
        logic [3:0]  gm;
        logic [33:0] e0, e1;
        @(negedge clk);
        p0_valid = v0; p0_addr = a0; p0_write = w0; p0_wdata = d0; p0_wmask = m0;
        p1_valid = v1; p1_addr = a1; p1_write = w1; p1_wdata = d1; p1_wmask = m1;
        #1;
        if (v0 && v1) g = (rr_model == 0) ? 1 : 0;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        else          g = -1;
        ga  = (g == 1) ? a1 : a0;
        gd  = (g == 1) ? d1 : d0;
        gw  = (g == 1) ? w1 : w0;
        gm  = (g == 1) ? m1 : m0;
        oor = ({2'b00, ga[31:2]} >= 32'd4096);
        e0  = (pend && pport == 0) ? {1'b1, perr, prdata} : 34'h0;
        e1  = (pend && pport == 1) ? {1'b1, perr, prdata} : 34'h0;
        obs_rdy = {p1_ready, p0_ready};
        chk("ready", 64'(obs_rdy), 64'({g == 1, g == 0}));
        if (g >= 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(ga));
            chk("mem_sdata", 64'(mem_sdata), 64'(gd));
            chk("mem_ctl", 64'({mem_lenable, mem_mask}),
                64'({!gw && !oor, (gw && !oor) ? gm : 4'h0}));
        end else begin
            chk("idle_bus", {mem_addr, mem_sdata}, 64'h0);
            chk("idle_ctl", 64'({mem_lenable, mem_mask}), 64'h0);
        end
        chk("p0_resp", 64'({p0_resp_valid, p0_resp_err, p0_resp_rdata}), 64'(e0));
        chk("p1_resp", 64'({p1_resp_valid, p1_resp_err, p1_resp_rdata}), 64'(e1));
        last_g = g;
        pend   = (g >= 0);
        if (g >= 0) begin
            rr_model = g;
            pport    = g;
            perr     = oor;
            prdata   = (!gw && !oor) ? ref_mem[ga[13:2]] : 32'h0;
            if (gw && !oor)
                for (int b = 0; b < 4; b++)
                    if (gm[b]) ref_mem[ga[13:2]][8*b +: 8] = gd[8*b +: 8];
        end
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic rand_req(output logic [31:0] a, output logic w,
                            output logic [31:0] d, output logic [3:0] m);
        logic [29:0] word;
        case ($urandom_range(0, 9))
            0:       word = 30'(4096 + $urandom_range(0, 255));
            1:       word = 30'h3FFFFFFF;
            default: word = 30'($urandom_range(0, 15));
        endcase
        a = {word, 2'($urandom_range(0, 3))};
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        m = 4'($urandom_range(0, 15));
    endtask

    initial begin
        logic [31:0] qa0, qa1, ra0, ra1, rd0, rd1;
        logic        rw0, rw1, rv0, rv1, h0, h1;
        logic [3:0]  rm0, rm1;

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        model_reset();
        p0_valid = 1'b1; p0_addr = 32'h10; p0_write = 1'b0; p0_wdata = 32'h0; p0_wmask = 4'h0;
        p1_valid = 1'b1; p1_addr = 32'h14; p1_write = 1'b0; p1_wdata = 32'h0; p1_wmask = 4'h0;

        // Held in reset with requests pending: nothing granted, all outputs quiet
        repeat (2) begin
            @(negedge clk); #1;
            chk_reset_outputs("por");
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        rst_n = 1'b1;

        // Store then load to the same word
        cyc(1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        cyc(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        chk("st_resp", 64'({p0_resp_valid, p0_resp_err, p0_resp_rdata}), 64'({2'b10, 32'h0}));
        idle();
        chk("raw_data", 64'({p0_resp_valid, p0_resp_rdata}), 64'({1'b1, 32'hDEADBEEF}));

        // Byte store, load back, then reset during the response cycle
        cyc(1'b1, 32'h20, 1'b1, 32'h00AB0000, 4'b0100, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        cyc(1'b1, 32'h20, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        p0_valid = 1'b0; p1_valid = 1'b0;
        #1;
        chk("rmw_resp", 64'({p0_resp_valid, p0_resp_err, p0_resp_rdata}), 64'({2'b10, 32'h11AB3344}));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        p0_valid = 1'b1; p1_valid = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk_reset_outputs("in_rst");
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        rst_n = 1'b1;

        // Both ports loading continuously: grants alternate starting with port 0
        qa0 = 32'h00000004;
        qa1 = 32'h00000020;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, qa0, 1'b0, 32'h0, 4'h0, 1'b1, qa1, 1'b0, 32'h0, 4'h0);
            chk("alt_grant", 64'(obs_rdy), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            if (last_g == 0) qa0 = qa0 + 32'h4;
            else             qa1 = qa1 + 32'h4;
        end

        // Out-of-range load and store; word 0 aliases 0x4000 in the low address bits
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h4000, 1'b0, 32'h0, 4'h0);
        chk("oor_ld_ctl", 64'({mem_lenable, mem_mask}), 64'h0);
        cyc(1'b1, 32'h4000, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        chk("oor_ld_resp", 64'({p1_resp_valid, p1_resp_err, p1_resp_rdata}), 64'({2'b11, 32'h0}));
        chk("oor_st_ctl", 64'({mem_lenable, mem_mask}), 64'h0);
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        chk("oor_st_resp", 64'({p0_resp_valid, p0_resp_err}), 64'(2'b11));
        idle();
        chk("oor_untouched", 64'(p0_resp_rdata), 64'(init_word(0)));

        // Port 1 alone, back-to-back stores
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h100 + 32'(4 * i), 1'b1, $urandom, 4'hF);
            chk("b2b_ready", 64'(p1_ready), 64'h1);
            if (i > 0)
                chk("b2b_resp", 64'({p1_resp_valid, p1_resp_err, p1_resp_rdata}), 64'({2'b10, 32'h0}));
        end
        idle();
        chk("b2b_last", 64'({p1_resp_valid, p1_resp_rdata}), 64'({1'b1, 32'h0}));

        // Random traffic; unaccepted requests are held, occasionally dropped
        h0 = 1'b0; h1 = 1'b0;
        ra0 = 32'h0; rw0 = 1'b0; rd0 = 32'h0; rm0 = 4'h0;
        ra1 = 32'h0; rw1 = 1'b0; rd1 = 32'h0; rm1 = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (h0) rv0 = ($urandom_range(0, 7) != 0);
            else begin
                rv0 = ($urandom_range(0, 3) != 0);
                rand_req(ra0, rw0, rd0, rm0);
            end
            if (h1) rv1 = ($urandom_range(0, 7) != 0);
            else begin
                rv1 = ($urandom_range(0, 3) != 0);
                rand_req(ra1, rw1, rd1, rm1);
            end
            cyc(rv0, ra0, rw0, rd0, rm0, rv1, ra1, rw1, rd1, rm1);
            h0 = rv0 && (last_g != 0);
            h1 = rv1 && (last_g != 1);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported, synchronous-read data memory between the CPU load/store unit (port 0) and a secondary master such as a debug or program loader (port 1). It grants one request per cycle using round-robin priority and drives the memory bus combinationally from the granted request. It tracks the one-cycle read latency of the memory and returns a response, with read data or an out-of-range error, to the port that issued the request. It sits between the two masters and the data memory, and is the only driver of the memory bus.

## Interface
- SIZE, 4096: memory depth in 32-bit words; word addresses at or above SIZE are out of range.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- pN_valid  in  1  request present on port N (N = 0, 1).
- pN_ready  out  1  request on port N accepted this cycle.
- pN_addr  in  32  byte address; bits [1:0] are ignored.
- pN_write  in  1  1 = store, 0 = load.
- pN_wdata  in  32  store data.
- pN_wmask  in  4  byte enables for a store; ignored for a load.
- pN_resp_valid  out  1  response for port N this cycle.
- pN_resp_rdata  out  32  load data; 0 for stores and for errors.
- pN_resp_err  out  1  the accepted request was out of range.
- mem_addr  out  32  memory address.
- mem_sdata  out  32  memory store data.
- mem_lenable  out  1  memory read enable.
- mem_mask  out  4  memory byte write enables.
- mem_ldata  in  32  memory read data; valid in the cycle after mem_lenable is sampled.

## Operation
- **Grant rules**
  - Only one port is valid: that port is granted.
  - Both ports are valid: the port not granted most recently wins. The last-granted register rr_last is set to 1 at reset, so port 0 wins the first conflict.
  - rr_last updates only when a grant occurs.
- **Handshake**
  - pN_ready is combinational and is high only for the granted port.
  - A request is accepted when pN_valid and pN_ready are both high.
  - Requesters hold addr, write, wdata and wmask stable until accepted.
  - The cycle in which a request is accepted is the issue cycle.
- **Memory drive in the issue cycle**
  - mem_addr = granted addr.
  - mem_sdata = granted wdata.
  - In-range load: mem_lenable = 1, mem_mask = 0.
  - In-range store: mem_mask = wmask, mem_lenable = 0.
  - Out-of-range request: mem_lenable = 0 and mem_mask = 0, so memory is untouched.
  - No grant: mem_lenable = 0, mem_mask = 0, mem_addr = 0 and mem_sdata = 0.
- **Range check**: a request is out of range when addr[31:2] >= SIZE, using a 30-bit unsigned compare.
- **Response stage registers**, loaded at the end of every issue cycle:
  - rsp_pend: a response is due.
  - rsp_port: which port issued.
  - rsp_rd: the request was a load.
  - rsp_err: the request was out of range.
  - rsp_pend clears at the end of any cycle with no issue.
- **Response outputs**, for the port selected by rsp_port:
  - pN_resp_valid = rsp_pend.
  - pN_resp_err = rsp_err.
  - pN_resp_rdata = mem_ldata, passed through combinationally, when rsp_rd = 1 and rsp_err = 0; otherwise 0.
  - The other port's response outputs are all 0.
- **Back-pressure**: responses have none, and masters must sink them.
- **Pipelining**: a new request may issue in the same cycle as the previous response. The memory output register holds the old data through that cycle, so sustained throughput is one request per cycle for any mix of loads and stores.
- **Ordering**: a store followed in the next cycle by a load to the same word returns the new data. Read-modify-write needs no extra hazard logic.

## Timing
- Reset values: pN_ready = 0, pN_resp_valid = 0, pN_resp_err = 0, pN_resp_rdata = 0, mem_lenable = 0, mem_mask = 0, mem_addr = 0, mem_sdata = 0, rsp_* = 0, rr_last = 1.
- Latency: a request issued in cycle T has its response in cycle T+1, for both loads and stores.
- Reset asserted mid-operation: any pending response is dropped immediately, with no response in the following cycle. No grant is made while rst_n is low.
- Reset released: the first grant is possible in the first cycle with rst_n high.
- Simultaneous requests: with both ports continuously valid, grants alternate 0,1,0,1, and neither port waits more than one cycle.
- A port that drops pN_valid before being granted loses its turn. rr_last does not change.

## Test plan
- Port 0 stores 0xDEADBEEF at 0x10 with mask 4'hF in cycle T, then loads 0x10 in T+1 -> resp_valid with err=0 at T+1, then p0_resp_rdata = 0xDEADBEEF at T+2.
- Byte store 0xAB with mask 4'b0100 to 0x20, which holds 0x11223344, then load 0x20 -> 0x11AB3344.
- Both ports continuously loading different addresses for 8 cycles -> grants 0,1,0,1,... One response per cycle, each routed to the issuing port with that port's data.
- Load at 0x4000 with SIZE=4096 -> mem_lenable = 0 in the issue cycle; resp_err = 1 and rdata = 0 in the next cycle. A store to 0x4000 leaves memory unchanged.
- Load issued, then rst_n pulled low in the response cycle -> resp_valid falls immediately; all outputs at reset values; the first post-reset conflict grants port 0.
- Port 1 alone issuing back-to-back stores -> p1_ready high every cycle; one p1_resp_valid pulse per store, each with rdata = 0.
